// File: rtl/pipeline_controller_pkg.sv
// Shared types and constants for the pipeline hazard controller.
//   ctrl_state_t : controller FSM states
//   FD/DE/EM/MW  : bit index of each pipeline register in stall/nullify
//   FLUSH_CNT_W  : width of the flush down-counter (FLUSH_CYCLES <= 15)
package pipeline_controller_pkg;

  typedef enum logic [1:0] {
    RUN         = 2'd0,
    MULDIV_WAIT = 2'd1,
    FLUSH       = 2'd2
  } ctrl_state_t;

  localparam int FD = 0;
  localparam int DE = 1;
  localparam int EM = 2;
  localparam int MW = 3;

  localparam int FLUSH_CNT_W = 4;

endpackage

// File: rtl/pipeline_controller_sat_counter.sv
// Saturating up-counter. Counts once per clock while inc_en_i is high and
// holds at all-ones instead of wrapping.
//   clk      : clock
//   reset    : asynchronous active-high reset, clears the count
//   inc_en_i : increment enable
//   count_o  : current count
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_en_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc_en_i && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipeline_controller.sv
// Pipeline hazard controller: turns hazard events into PC hold, per-register
// stall and nullify controls for a 5-stage pipeline (FD, DE, EM, MW).
//   clk          : clock
//   reset        : asynchronous active-high reset
//   load_use     : D-stage needs the result of an E-stage load
//   branch_taken : E-stage branch/jump resolved taken
//   muldiv_start : E-stage issues a multi-cycle mul/div
//   muldiv_done  : mul/div result valid this cycle
//   exception    : M-stage instruction raised an exception
//   pc_stall     : hold the PC
//   stall        : per-register stall   [FD,DE,EM,MW] = bits [0..3]
//   nullify      : per-register nullify [FD,DE,EM,MW] = bits [0..3]
//   muldiv_abort : one-cycle pulse cancelling an in-flight mul/div
//   stall_cycles : saturating count of cycles with pc_stall high
//
// State table
//   RUN         | normal issue; load-use bubbles and branch squashes
//   MULDIV_WAIT | FD/DE frozen until the mul/div result returns
//   FLUSH       | FD held nullified for FLUSH_CYCLES after an exception
module pipeline_controller
  import pipeline_controller_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_use,
  input  logic             branch_taken,
  input  logic             muldiv_start,
  input  logic             muldiv_done,
  input  logic             exception,
  output logic             pc_stall,
  output logic [3:0]       stall,
  output logic [3:0]       nullify,
  output logic             muldiv_abort,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

  ctrl_state_t            state_q, state_d;
  logic [FLUSH_CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Outputs are decoded from state and the current inputs so that a hazard
  // is acted on in the same cycle it is reported.
  always_comb begin
    state_d      = state_q;
    flush_cnt_d  = flush_cnt_q;
    pc_stall     = 1'b0;
    stall        = 4'b0000;
    nullify      = 4'b0000;
    muldiv_abort = 1'b0;

    if (reset) begin
      // Everything in flight is discarded while reset is held.
      nullify = 4'b1111;
    end else if (exception) begin
      nullify      = 4'b1111;
      muldiv_abort = (state_q == MULDIV_WAIT);
      state_d      = FLUSH;
      flush_cnt_d  = FLUSH_LOAD;
    end else begin
      unique case (state_q)
        MULDIV_WAIT: begin
          if (muldiv_done) begin
            state_d = RUN;
          end else begin
            pc_stall    = 1'b1;
            stall[FD]   = 1'b1;
            stall[DE]   = 1'b1;
            nullify[EM] = 1'b1;
          end
        end
        FLUSH: begin
          nullify[FD] = 1'b1;
          if (flush_cnt_q == '0) begin
            state_d = RUN;
          end else begin
            flush_cnt_d = flush_cnt_q - FLUSH_CNT_W'(1);
          end
        end
        default: begin
          state_d = RUN;
          if (muldiv_start) begin
            // A result that is ready in the issue cycle needs no wait.
            if (!muldiv_done) begin
              pc_stall    = 1'b1;
              stall[FD]   = 1'b1;
              stall[DE]   = 1'b1;
              nullify[EM] = 1'b1;
              state_d     = MULDIV_WAIT;
            end
          end else if (branch_taken) begin
            nullify[FD] = 1'b1;
            nullify[DE] = 1'b1;
          end else if (load_use) begin
            pc_stall    = 1'b1;
            stall[FD]   = 1'b1;
            nullify[DE] = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_stall_cnt (
    .clk      (clk),
    .reset    (reset),
    .inc_en_i (pc_stall),
    .count_o  (stall_cycles)
  );

endmodule

// File: tb/tb_pipeline_controller.sv
module tb_pipeline_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 1: default parameters
  logic        reset, load_use, branch_taken, muldiv_start, muldiv_done, exception;
  logic        pc_stall, muldiv_abort;
  logic [3:0]  stall, nullify;
  logic [15:0] stall_cycles;

  // Instance 2: CNT_W=4, FLUSH_CYCLES=1
  logic        rst2, lu2, br2, ms2, md2, exc2;
  logic        pc_stall2, abort2;
  logic [3:0]  stall2, nullify2;
  logic [3:0]  sc2;

  int tests = 0;
  int fails = 0;

  pipeline_controller dut (
    .clk(clk), .reset(reset), .load_use(load_use), .branch_taken(branch_taken),
    .muldiv_start(muldiv_start), .muldiv_done(muldiv_done), .exception(exception),
    .pc_stall(pc_stall), .stall(stall), .nullify(nullify),
    .muldiv_abort(muldiv_abort), .stall_cycles(stall_cycles)
  );

  pipeline_controller #(.FLUSH_CYCLES(1), .CNT_W(4)) dut2 (
    .clk(clk), .reset(rst2), .load_use(lu2), .branch_taken(br2),
    .muldiv_start(ms2), .muldiv_done(md2), .exception(exc2),
    .pc_stall(pc_stall2), .stall(stall2), .nullify(nullify2),
    .muldiv_abort(abort2), .stall_cycles(sc2)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks the combinational outputs of instance 1 for the current cycle.
  task automatic outs(input string tag, input logic pc, input logic [3:0] st,
                      input logic [3:0] nu, input logic ab);
    chk({tag, ".pc_stall"}, {15'd0, pc_stall}, {15'd0, pc});
    chk({tag, ".stall"}, {12'd0, stall}, {12'd0, st});
    chk({tag, ".nullify"}, {12'd0, nullify}, {12'd0, nu});
    chk({tag, ".abort"}, {15'd0, muldiv_abort}, {15'd0, ab});
    chk({tag, ".overlap"}, {12'd0, stall & nullify}, 16'd0);
  endtask

  task automatic set_in(input logic lu, input logic br, input logic ms,
                        input logic md, input logic ex);
    @(negedge clk);
    load_use = lu; branch_taken = br; muldiv_start = ms; muldiv_done = md; exception = ex;
    #1;
  endtask

  initial begin
    reset = 1'b1; load_use = 0; branch_taken = 0; muldiv_start = 0; muldiv_done = 0; exception = 0;
    rst2 = 1'b1; lu2 = 0; br2 = 0; ms2 = 0; md2 = 0; exc2 = 0;
    #2;
    outs("reset", 1'b0, 4'b0000, 4'b1111, 1'b0);
    chk("reset.sc", stall_cycles, 16'd0);
    @(negedge clk);
    reset = 1'b0; rst2 = 1'b0;
    #1;
    outs("post_reset", 1'b0, 4'b0000, 4'b0000, 1'b0);

    // load-use bubble
    set_in(1, 0, 0, 0, 0); outs("load_use", 1'b1, 4'b0001, 4'b0010, 1'b0);
    set_in(0, 0, 0, 0, 0); outs("after_lu", 1'b0, 4'b0000, 4'b0000, 1'b0);
    chk("lu.sc", stall_cycles, 16'd1);

    // branch wins over load-use
    set_in(1, 1, 0, 0, 0); outs("branch_lu", 1'b0, 4'b0000, 4'b0011, 1'b0);
    set_in(0, 0, 0, 0, 0); outs("after_br", 1'b0, 4'b0000, 4'b0000, 1'b0);
    chk("br.sc", stall_cycles, 16'd1);

    // mul/div with done on the 5th cycle; branch/load-use ignored while waiting
    set_in(0, 0, 1, 0, 0); outs("md1", 1'b1, 4'b0011, 4'b0100, 1'b0);
    set_in(0, 0, 0, 0, 0); outs("md2", 1'b1, 4'b0011, 4'b0100, 1'b0);
    set_in(1, 1, 0, 0, 0); outs("md3", 1'b1, 4'b0011, 4'b0100, 1'b0);
    set_in(0, 0, 0, 0, 0); outs("md4", 1'b1, 4'b0011, 4'b0100, 1'b0);
    set_in(0, 0, 0, 1, 0); outs("md5_done", 1'b0, 4'b0000, 4'b0000, 1'b0);
    set_in(0, 0, 0, 0, 0); outs("md_after", 1'b0, 4'b0000, 4'b0000, 1'b0);
    chk("md.sc", stall_cycles, 16'd5);

    // zero-wait mul/div stays in RUN
    set_in(0, 0, 1, 1, 0); outs("zw", 1'b0, 4'b0000, 4'b0000, 1'b0);
    set_in(0, 0, 0, 0, 0); outs("zw_after", 1'b0, 4'b0000, 4'b0000, 1'b0);
    chk("zw.sc", stall_cycles, 16'd5);

    // exception on the 2nd MULDIV_WAIT cycle; FLUSH ignores other requests
    set_in(0, 0, 1, 0, 0); outs("ab1", 1'b1, 4'b0011, 4'b0100, 1'b0);
    set_in(0, 0, 0, 0, 1); outs("ab_exc", 1'b0, 4'b0000, 4'b1111, 1'b1);
    set_in(1, 1, 1, 0, 0); outs("ab_fl1", 1'b0, 4'b0000, 4'b0001, 1'b0);
    set_in(1, 1, 1, 0, 0); outs("ab_fl2", 1'b0, 4'b0000, 4'b0001, 1'b0);
    set_in(0, 0, 0, 0, 0); outs("ab_run", 1'b0, 4'b0000, 4'b0000, 1'b0);
    chk("ab.sc", stall_cycles, 16'd6);

    // exception in RUN, then again in the 1st FLUSH cycle
    set_in(0, 0, 0, 0, 1); outs("ex_run", 1'b0, 4'b0000, 4'b1111, 1'b0);
    set_in(0, 0, 0, 0, 1); outs("ex_fl1", 1'b0, 4'b0000, 4'b1111, 1'b0);
    set_in(0, 0, 0, 0, 0); outs("ex_fl2", 1'b0, 4'b0000, 4'b0001, 1'b0);
    set_in(0, 0, 0, 0, 0); outs("ex_fl3", 1'b0, 4'b0000, 4'b0001, 1'b0);
    set_in(0, 0, 0, 0, 0); outs("ex_run2", 1'b0, 4'b0000, 4'b0000, 1'b0);

    // reset asserted mid-MULDIV_WAIT abandons the operation
    set_in(0, 0, 1, 0, 0); outs("rw1", 1'b1, 4'b0011, 4'b0100, 1'b0);
    set_in(0, 0, 0, 0, 0); outs("rw2", 1'b1, 4'b0011, 4'b0100, 1'b0);
    chk("rw.sc", stall_cycles, 16'd7);
    #2 reset = 1'b1;
    #1;
    outs("rw_reset", 1'b0, 4'b0000, 4'b1111, 1'b0);
    chk("rw_reset.sc", stall_cycles, 16'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    outs("rw_rel", 1'b0, 4'b0000, 4'b0000, 1'b0);
    set_in(0, 0, 0, 0, 0); outs("rw_run", 1'b0, 4'b0000, 4'b0000, 1'b0);
    chk("rw_run.sc", stall_cycles, 16'd0);

    // instance 2: single-cycle FLUSH
    @(negedge clk); exc2 = 1'b1; #1;
    chk("f1_exc.nullify", {12'd0, nullify2}, 16'h000f);
    @(negedge clk); exc2 = 1'b0; #1;
    chk("f1_flush.nullify", {12'd0, nullify2}, 16'h0001);
    @(negedge clk); #1;
    chk("f1_run.nullify", {12'd0, nullify2}, 16'h0000);
    chk("f1_run.pc_stall", {15'd0, pc_stall2}, 16'd0);

    // instance 2: 4-bit counter saturates, reset clears it asynchronously
    @(negedge clk); lu2 = 1'b1; #1;
    chk("sat0.sc", {12'd0, sc2}, 16'd0);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk); #1;
      if (i == 10) chk("sat10.sc", {12'd0, sc2}, 16'd10);
      if (i == 20) chk("sat20.sc", {12'd0, sc2}, 16'd15);
    end
    #2 rst2 = 1'b1;
    #1;
    chk("sat_rst.sc", {12'd0, sc2}, 16'd0);
    chk("sat_rst.nullify", {12'd0, nullify2}, 16'h000f);
    chk("sat_rst.pc_stall", {15'd0, pc_stall2}, 16'd0);
    @(negedge clk); rst2 = 1'b0; lu2 = 1'b0; #1;
    chk("sat_rel.sc", {12'd0, sc2}, 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipeline_controller.md
PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

Interface
REQ-001 Parameter FLUSH_CYCLES, default 2, range 1..15: cycles FD is held nullified after an exception.
REQ-002 Parameter CNT_W, default 16: width of stall_cycles.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 load_use  in  1  D-stage instruction needs the result of an E-stage load.
REQ-006 branch_taken  in  1  E-stage branch/jump resolved taken.
REQ-007 muldiv_start  in  1  E-stage instruction issues a multi-cycle mul/div.
REQ-008 muldiv_done  in  1  mul/div result valid this cycle.
REQ-009 exception  in  1  M-stage instruction raised an exception.
REQ-010 pc_stall  out  1  hold the PC.
REQ-011 stall  out  4  per-register stall, index 0=FD, 1=DE, 2=EM, 3=MW.
REQ-012 nullify  out  4  per-register nullify, same indexing.
REQ-013 muldiv_abort  out  1  one-cycle pulse cancelling an in-flight mul/div.
REQ-014 stall_cycles  out  CNT_W  saturating count of cycles with pc_stall=1.

Function
REQ-015 Three states: RUN, MULDIV_WAIT, FLUSH. All outputs except stall_cycles are combinational from state and inputs.
REQ-016 Event priority, highest first: exception, muldiv (start or WAIT), branch_taken, load_use.
REQ-017 Quiet RUN: pc_stall=0, stall=0000, nullify=0000.
REQ-018 RUN with load_use only: pc_stall=1, stall=0001, nullify=0010 (bubble into DE); state stays RUN.
REQ-019 RUN with branch_taken, with or without load_use: nullify=0011, stall=0000, pc_stall=0.
REQ-020 RUN with muldiv_start: pc_stall=1, stall=0011, nullify=0100; next state MULDIV_WAIT.
REQ-021 MULDIV_WAIT with muldiv_done=0: same outputs as REQ-020; branch_taken and load_use ignored.
REQ-022 MULDIV_WAIT with muldiv_done=1: outputs as quiet RUN; next state RUN.
REQ-023 muldiv_start and muldiv_done together in RUN: treat as a zero-wait op; outputs as quiet RUN; stay RUN.
REQ-024 exception in any state: pc_stall=0, stall=0000, nullify=1111.
REQ-025 On exception, the next state is FLUSH and the flush counter loads FLUSH_CYCLES-1.
REQ-026 On exception in MULDIV_WAIT, muldiv_abort=1 for exactly that cycle.
REQ-027 FLUSH: nullify=0001, pc_stall=0; counter decrements each cycle; exit to RUN on the cycle the counter reads 0.
REQ-028 With FLUSH_CYCLES=1, FLUSH lasts one cycle.
REQ-029 FLUSH ignores load_use, branch_taken and muldiv_start.
REQ-030 A new exception in FLUSH reloads the counter to FLUSH_CYCLES-1.
REQ-031 stall_cycles increments each cycle pc_stall=1 and saturates at all-ones; it never wraps.
REQ-032 stall and nullify never both assert for the same register in the same cycle.

Reset
REQ-033 While reset=1, asynchronously: state=RUN, flush counter=0, stall_cycles=0, pc_stall=0, stall=0000, nullify=1111, muldiv_abort=0.
REQ-034 Reset asserted mid-MULDIV_WAIT or mid-FLUSH abandons the operation; muldiv_abort stays 0.
REQ-035 The first cycle after reset release behaves as quiet RUN unless inputs request otherwise.

Structure
REQ-036 The shared signals package holds ctrl_state_t (RUN, MULDIV_WAIT, FLUSH) and the stage index constants FD=0, DE=1, EM=2, MW=3.
REQ-037 One sub-module, sat_counter (parameter width; ports: increment enable, count output), implements stall_cycles.

Verification
REQ-038 load_use=1 for 1 cycle in RUN -> pc_stall=1, stall=0001, nullify=0010 for 1 cycle; stall_cycles=1.
REQ-039 branch_taken=1 and load_use=1 together -> nullify=0011, pc_stall=0; stall_cycles unchanged.
REQ-040 muldiv_start, then muldiv_done on the 5th cycle -> stall=0011 and nullify=0100 for 4 cycles, then quiet RUN; stall_cycles=4.
REQ-041 Exception on the 2nd MULDIV_WAIT cycle -> nullify=1111 and muldiv_abort=1 for 1 cycle, then nullify=0001 for 2 cycles (FLUSH_CYCLES=2), then RUN.
REQ-042 Exception in the 1st FLUSH cycle -> FLUSH extends for 2 further cycles.
REQ-043 Constant load_use with CNT_W=4 for 20 cycles -> stall_cycles saturates at 15; reset mid-run clears it to 0 asynchronously, and nullify=1111 while reset=1.
